// File: rtl/pipeline_stage_sequencer.sv
// Steps each instruction through IF/ID/EX/MEM/WB with stall, two-word fetch and halt/resume.
// Also keeps free-running cycle and retired-instruction counters for the control path.

`ifndef STAGE_COUNT
`define STAGE_COUNT 3
`endif
`ifndef STAGE_IF
`define STAGE_IF  3'd0
`define STAGE_ID  3'd1
`define STAGE_EX  3'd2
`define STAGE_MEM 3'd3
`define STAGE_WB  3'd4
`endif

module pipeline_stage_sequencer #(
    parameter int unsigned CYCLE_CNT_WIDTH = 16,
    parameter int unsigned INSTR_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       two_word,
    input  logic                       halt_req,
    input  logic                       resume,
    output logic [`STAGE_COUNT-1:0]    pipeline_stage,
    output logic                       second_word,
    output logic                       pc_inc,
    output logic                       instr_retired,
    output logic                       halted,
    output logic [CYCLE_CNT_WIDTH-1:0] cycle_count,
    output logic [INSTR_CNT_WIDTH-1:0] instr_count
);

    typedef enum logic [2:0] {
        StIf,
        StId,
        StEx,
        StMem,
        StWb,
        StHalted
    } state_e;

    state_e                     state_q, state_d;
    logic [`STAGE_COUNT-1:0]    stage_q, stage_d;
    logic                       second_word_q, second_word_d;
    logic [CYCLE_CNT_WIDTH-1:0] cycle_count_q, cycle_count_d;
    logic [INSTR_CNT_WIDTH-1:0] instr_count_q, instr_count_d;

    // Next-state logic; stall freezes every pipeline state but not HALTED.
    always_comb begin
        state_d       = state_q;
        second_word_d = second_word_q;
        unique case (state_q)
            StIf: if (!stall) state_d = StId;
            StId: begin
                if (!stall) begin
                    if (two_word && !second_word_q) begin
                        state_d       = StIf;
                        second_word_d = 1'b1;
                    end else begin
                        state_d       = StEx;
                        second_word_d = 1'b0;
                    end
                end
            end
            StEx:     if (!stall) state_d = StMem;
            StMem:    if (!stall) state_d = StWb;
            StWb:     if (!stall) state_d = halt_req ? StHalted : StIf;
            StHalted: if (resume) state_d = StIf;
            default: begin
                state_d       = StIf;
                second_word_d = 1'b0;
            end
        endcase
    end

    // HALTED reports WB so downstream gates none of the IF..MEM actions.
    always_comb begin
        stage_d = `STAGE_IF;
        unique case (state_d)
            StIf:     stage_d = `STAGE_IF;
            StId:     stage_d = `STAGE_ID;
            StEx:     stage_d = `STAGE_EX;
            StMem:    stage_d = `STAGE_MEM;
            StWb:     stage_d = `STAGE_WB;
            StHalted: stage_d = `STAGE_WB;
            default:  stage_d = `STAGE_IF;
        endcase
    end

    always_comb begin
        pc_inc        = (state_q == StIf) && !stall;
        instr_retired = (state_q == StWb) && !stall;
        halted        = (state_q == StHalted);
    end

    always_comb begin
        cycle_count_d = cycle_count_q;
        instr_count_d = instr_count_q;
        if (state_q != StHalted) begin
            cycle_count_d = cycle_count_q + CYCLE_CNT_WIDTH'(1);
        end
        if (instr_retired) begin
            instr_count_d = instr_count_q + INSTR_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIf;
            stage_q       <= `STAGE_IF;
            second_word_q <= 1'b0;
            cycle_count_q <= '0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            stage_q       <= stage_d;
            second_word_q <= second_word_d;
            cycle_count_q <= cycle_count_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign pipeline_stage = stage_q;
    assign second_word    = second_word_q;
    assign cycle_count    = cycle_count_q;
    assign instr_count    = instr_count_q;

endmodule

// File: tb/tb_pipeline_stage_sequencer.sv
// Self-checking bench: directed vector table, async-reset and wrap corners,
// then random stimulus against a per-instruction behavioural model.

`ifndef STAGE_COUNT
`define STAGE_COUNT 3
`endif
`ifndef STAGE_IF
`define STAGE_IF  3'd0
`define STAGE_ID  3'd1
`define STAGE_EX  3'd2
`define STAGE_MEM 3'd3
`define STAGE_WB  3'd4
`endif

module tb_pipeline_stage_sequencer;

    logic clk = 1'b0;
    logic reset, stall, two_word, halt_req, resume;
    logic [`STAGE_COUNT-1:0] pipeline_stage;
    logic second_word, pc_inc, instr_retired, halted;
    logic [15:0] cycle_count, instr_count;

    logic reset4;
    logic zero4 = 1'b0;
    logic [`STAGE_COUNT-1:0] stage4;
    logic sw4, pc4, rt4, hl4;
    logic [3:0] cyc4, ins4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_stage_sequencer #(
        .CYCLE_CNT_WIDTH(16),
        .INSTR_CNT_WIDTH(16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .two_word      (two_word),
        .halt_req      (halt_req),
        .resume        (resume),
        .pipeline_stage(pipeline_stage),
        .second_word   (second_word),
        .pc_inc        (pc_inc),
        .instr_retired (instr_retired),
        .halted        (halted),
        .cycle_count   (cycle_count),
        .instr_count   (instr_count)
    );

    pipeline_stage_sequencer #(
        .CYCLE_CNT_WIDTH(4),
        .INSTR_CNT_WIDTH(4)
    ) dut4 (
        .clk           (clk),
        .reset         (reset4),
        .stall         (zero4),
        .two_word      (zero4),
        .halt_req      (zero4),
        .resume        (zero4),
        .pipeline_stage(stage4),
        .second_word   (sw4),
        .pc_inc        (pc4),
        .instr_retired (rt4),
        .halted        (hl4),
        .cycle_count   (cyc4),
        .instr_count   (ins4)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        stall    = 1'b0;
        two_word = 1'b0;
        halt_req = 1'b0;
        resume   = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic st, tw, hr, rs;
        int   stage;
        logic sw, pc, rt, hl;
    } vec_t;

    // Behavioural model: stage as an integer that advances by one, plus flags.
    int          m_stage;
    bit          m_sw, m_halted;
    logic [15:0] m_cyc, m_ins;

    task automatic model_reset();
        m_stage  = 0;
        m_sw     = 0;
        m_halted = 0;
        m_cyc    = 0;
        m_ins    = 0;
    endtask

    task automatic model_step(input bit st, input bit tw, input bit hr, input bit rs);
        if (!m_halted) m_cyc = m_cyc + 16'd1;
        if (m_halted) begin
            if (rs) begin
                m_halted = 0;
                m_stage  = 0;
            end
        end else if (!st) begin
            if (m_stage == 1 && tw && !m_sw) begin
                m_sw    = 1;
                m_stage = 0;
            end else if (m_stage == 4) begin
                m_ins = m_ins + 16'd1;
                if (hr) m_halted = 1;
                else    m_stage  = 0;
            end else begin
                if (m_stage == 1) m_sw = 0;
                m_stage = m_stage + 1;
            end
        end
    endtask

    vec_t vecs[20];
    int   pc_cnt;

    initial begin
        // stall two_word halt_req resume | stage sw pc_inc retired halted
        vecs[0]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
        vecs[1]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        vecs[2]  = '{0, 0, 0, 0, 2, 0, 0, 0, 0};
        vecs[3]  = '{0, 0, 0, 0, 3, 0, 0, 0, 0};
        vecs[4]  = '{0, 0, 0, 0, 4, 0, 0, 1, 0};
        vecs[5]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
        vecs[6]  = '{0, 1, 0, 0, 1, 0, 0, 0, 0};
        vecs[7]  = '{0, 1, 0, 0, 0, 1, 1, 0, 0};
        vecs[8]  = '{0, 1, 0, 0, 1, 1, 0, 0, 0};
        vecs[9]  = '{0, 0, 0, 0, 2, 0, 0, 0, 0};
        vecs[10] = '{1, 0, 0, 0, 3, 0, 0, 0, 0};
        vecs[11] = '{1, 0, 0, 0, 3, 0, 0, 0, 0};
        vecs[12] = '{1, 0, 0, 0, 3, 0, 0, 0, 0};
        vecs[13] = '{0, 0, 0, 0, 3, 0, 0, 0, 0};
        vecs[14] = '{1, 0, 1, 0, 4, 0, 0, 0, 0};
        vecs[15] = '{0, 0, 1, 0, 4, 0, 0, 1, 0};
        vecs[16] = '{1, 0, 0, 0, 4, 0, 0, 0, 1};
        vecs[17] = '{0, 0, 0, 0, 4, 0, 0, 0, 1};
        vecs[18] = '{1, 0, 0, 1, 4, 0, 0, 0, 1};
        vecs[19] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};

        reset4 = 1'b1;
        do_reset();
        #1;
        check("reset_stage", pipeline_stage, `STAGE_IF);
        check("reset_cycle", cycle_count, 0);
        check("reset_instr", instr_count, 0);
        check("reset_halted", halted, 0);
        check("reset_sw", second_word, 0);

        // Directed table.
        for (int i = 0; i < 20; i++) begin
            stall    = vecs[i].st;
            two_word = vecs[i].tw;
            halt_req = vecs[i].hr;
            resume   = vecs[i].rs;
            #1;
            check($sformatf("vec%0d_stage", i), pipeline_stage, vecs[i].stage);
            check($sformatf("vec%0d_sw", i), second_word, vecs[i].sw);
            check($sformatf("vec%0d_pc_inc", i), pc_inc, vecs[i].pc);
            check($sformatf("vec%0d_retired", i), instr_retired, vecs[i].rt);
            check($sformatf("vec%0d_halted", i), halted, vecs[i].hl);
            @(negedge clk);
        end
        check("table_cycle_count", cycle_count, 17);
        check("table_instr_count", instr_count, 2);

        // Ten plain cycles: pc_inc on cycles 0 and 5 only.
        do_reset();
        pc_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (pc_inc) begin
                pc_cnt++;
                check($sformatf("pc_inc_cycle%0d", c), (c == 0 || c == 5) ? 1 : 0, 1);
            end
            @(negedge clk);
        end
        check("ten_pc_inc_count", pc_cnt, 2);
        check("ten_cycle_count", cycle_count, 10);
        check("ten_instr_count", instr_count, 2);

        // Async reset between edges while in EX.
        do_reset();
        @(negedge clk);
        @(negedge clk);
        check("mid_ex_stage", pipeline_stage, `STAGE_EX);
        #2;
        reset = 1'b1;
        #1;
        check("async_stage", pipeline_stage, `STAGE_IF);
        check("async_cycle", cycle_count, 0);
        check("async_halted", halted, 0);
        @(negedge clk);
        reset = 1'b0;

        // Narrow counters wrap: 20 clocks -> 4 mod 16, 4 retirements.
        reset4 = 1'b0;
        repeat (20) @(negedge clk);
        check("wrap_cycle4", cyc4, 4);
        check("wrap_instr4", ins4, 4);

        // Random stimulus against the model.
        do_reset();
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            stall    = ($urandom_range(0, 3) == 0);
            two_word = $urandom_range(0, 1);
            halt_req = ($urandom_range(0, 6) == 0);
            resume   = ($urandom_range(0, 2) == 0);
            #1;
            check("rnd_stage", pipeline_stage, m_halted ? 4 : m_stage);
            check("rnd_sw", second_word, m_sw);
            check("rnd_pc_inc", pc_inc, (!m_halted && m_stage == 0 && !stall) ? 1 : 0);
            check("rnd_retired", instr_retired, (!m_halted && m_stage == 4 && !stall) ? 1 : 0);
            check("rnd_halted", halted, m_halted);
            check("rnd_cycle", cycle_count, m_cyc);
            check("rnd_instr", instr_count, m_ins);
            @(posedge clk);
            model_step(stall, two_word, halt_req, resume);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
